// File: rtl/full_subtractor_cell.sv
// One-bit full-subtractor leaf cell: d = a - b - bin, with the borrow passed to the next bit.
module full_subtractor_cell (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bo
);

  assign d  = a ^ b ^ bin;
  assign bo = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/full_subtractor.sv
// WIDTH-bit ripple-borrow subtractor (a - b - bin) with a zero-latency combinational
// result and a one-cycle registered copy qualified by out_valid.
module full_subtractor #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  input  logic             in_valid,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic [WIDTH-1:0] diff_q,
  output logic             bout_q,
  output logic             out_valid
);

  logic [WIDTH:0]   borrow;
  logic [WIDTH-1:0] diff_d;
  logic             bout_d;
  logic             valid_d;
  logic             valid_q;

  assign borrow[0] = bin;

  // Borrow ripples LSB to MSB; the final borrow is the borrow-out of the whole word.
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    full_subtractor_cell u_cell (
      .a   (a[i]),
      .b   (b[i]),
      .bin (borrow[i]),
      .d   (diff[i]),
      .bo  (borrow[i+1])
    );
  end

  assign bout = borrow[WIDTH];

  always_comb begin
    diff_d  = diff_q;
    bout_d  = bout_q;
    valid_d = 1'b0;
    if (in_valid) begin
      diff_d  = diff;
      bout_d  = bout;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      diff_q  <= '0;
      bout_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      diff_q  <= diff_d;
      bout_q  <= bout_d;
      valid_q <= valid_d;
    end
  end

  assign out_valid = valid_q;

endmodule

// File: tb/tb_full_subtractor.sv
// Scoreboard bench for full_subtractor: a 1-bit instance for the truth table and an
// 8-bit instance whose registered results are checked by an independent monitor.
module tb_full_subtractor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 1-bit instance
  logic rst1 = 1'b1, a1 = 1'b0, b1 = 1'b0, bin1 = 1'b0, iv1 = 1'b0;
  logic diff1, bout1, diffq1, boutq1, ov1;

  full_subtractor #(.WIDTH(1)) u1 (
    .clk(clk), .rst(rst1), .a(a1), .b(b1), .bin(bin1), .in_valid(iv1),
    .diff(diff1), .bout(bout1), .diff_q(diffq1), .bout_q(boutq1), .out_valid(ov1)
  );

  // 8-bit instance
  logic       rst8 = 1'b1, bin8 = 1'b0, iv8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic [7:0] diff8, diffq8;
  logic       bout8, boutq8, ov8;

  full_subtractor #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst8), .a(a8), .b(b8), .bin(bin8), .in_valid(iv8),
    .diff(diff8), .bout(bout8), .diff_q(diffq8), .bout_q(boutq8), .out_valid(ov8)
  );

  int unsigned checks   = 0;
  int unsigned failures = 0;
  logic [8:0]  sb_q[$];     // expected {bout_q, diff_q} per captured cycle
  logic [8:0]  last_cap = '0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every cycle, reset -> zeros; out_valid -> pop and compare; else hold.
  initial begin
    logic       rs;
    logic [8:0] e;
    forever begin
      @(posedge clk);
      rs = rst8;
      #1;
      if (rs) begin
        chk("rst8_regs", {7'd0, ov8, boutq8, diffq8}, 16'h0);
        last_cap = '0;
      end else if (ov8) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_valid", 16'd1, 16'd0);
        end else begin
          e = sb_q.pop_front();
          chk("reg_result", {7'd0, boutq8, diffq8}, {7'd0, e});
          chk("reg_lag", 16'(sb_q.size()), 16'd0);
          last_cap = e;
        end
      end else begin
        chk("reg_hold", {7'd0, boutq8, diffq8}, {7'd0, last_cap});
      end
    end
  end

  task automatic drive8(input logic [7:0] a, input logic [7:0] b, input logic bin,
                        input logic iv, input logic rst,
                        input logic [7:0] exp_d, input logic exp_b);
    @(negedge clk);
    a8 = a; b8 = b; bin8 = bin; iv8 = iv; rst8 = rst;
    #1;
    chk("comb8", {7'd0, bout8, diff8}, {7'd0, exp_b, exp_d});
    if (iv && !rst) sb_q.push_back({exp_b, exp_d});
  endtask

  // 1-bit truth table: index {a,b,bin} -> {diff,bout}
  logic [1:0] tt [8] = '{2'b00, 2'b11, 2'b11, 2'b01, 2'b10, 2'b00, 2'b00, 2'b11};

  initial begin
    logic [2:0] v;
    logic [7:0] ra, rb;
    logic       rbin, riv;
    logic [8:0] ref9;

    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] v;
    logic [7:0] ra, rb;
    logic       rbin, riv;
    logic [8:0] ref9;

    @(negedge clk);
    chk("rst1_regs", {13'd0, ov1, boutq1, diffq1}, 16'h0);

    // Sweep with reset released and capture enabled
    rst1 = 1'b0; iv1 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      v = 3'(i);
      {a1, b1, bin1} = v;
      #1;
      chk("tt1", {14'd0, diff1, bout1}, {14'd0, tt[i]});
    end
    @(negedge clk);
    chk("reg1_last", {13'd0, ov1, diffq1, boutq1}, {13'd0, 1'b1, 2'b11});

    // Sweep with reset held; capture requested but reset wins
    rst1 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      v = 3'(i);
      {a1, b1, bin1} = v;
      #1;
      chk("tt1_rst", {14'd0, diff1, bout1}, {14'd0, tt[i]});
      chk("rst1_hold", {13'd0, ov1, boutq1, diffq1}, 16'h0);
    end

    // 8-bit directed
    drive8(8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
    drive8(8'h05, 8'h03, 1'b1, 1'b1, 1'b0, 8'h01, 1'b0);
    drive8(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    drive8(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    drive8(8'h00, 8'h01, 1'b0, 1'b1, 1'b0, 8'hFF, 1'b1);
    drive8(8'h00, 8'hFF, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1);
    drive8(8'h80, 8'h7F, 1'b0, 1'b1, 1'b0, 8'h01, 1'b0);
    drive8(8'hFF, 8'hFF, 1'b1, 1'b1, 1'b0, 8'hFF, 1'b1);
    drive8(8'hFF, 8'h00, 1'b1, 1'b1, 1'b0, 8'hFE, 1'b0);
    drive8(8'h10, 8'h01, 1'b0, 1'b0, 1'b0, 8'h0F, 1'b0);
    // Reset and in_valid on the same edge: reset wins
    drive8(8'hAA, 8'h55, 1'b0, 1'b1, 1'b1, 8'h55, 1'b0);
    drive8(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);

    // Random against a 9-bit reference subtraction
    for (int i = 0; i < 1000; i++) begin
      ra   = 8'($urandom);
      rb   = 8'($urandom);
      rbin = 1'($urandom);
      riv  = 1'($urandom);
      ref9 = {1'b0, ra} - {1'b0, rb} - {8'd0, rbin};
      drive8(ra, rb, rbin, riv, 1'b0, ref9[7:0], ref9[8]);
    end

    drive8(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    drive8(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("sb_drained", 16'(sb_q.size()), 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
